// File: rtl/rosc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronised osc_in rising edges over a gate window of clk cycles.
// Optional min/max tracking of results is enabled with the ROSC_MINMAX_EN macro.
module rosc_freq_meter #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              osc_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
`ifdef ROSC_MINMAX_EN
    ,
    input  logic              minmax_clr,
    output logic [CNT_W-1:0]  min_count,
    output logic [CNT_W-1:0]  max_count
`endif
);

    // Handshake: the result is transferred in a cycle where result_valid and result_ready are both high;
    // result_valid stays high with count/overflow stable until that happens.

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    state_t             state, state_nx;
    logic               sync_a, sync_b, hist;
    logic               arm_cnt, arm_nx;
    logic [GATE_W-1:0]  win_cnt, win_nx;
    logic [CNT_W-1:0]   count_q, count_nx;
    logic               ovf_q, ovf_nx;
    logic               busy_q, valid_q;
    logic               rise;

    assign rise = sync_b & ~hist;

    always_comb begin
        state_nx = state;
        arm_nx   = arm_cnt;
        win_nx   = win_cnt;
        count_nx = count_q;
        ovf_nx   = ovf_q;
        case (state)
            IDLE: begin
                if (start) begin
                    win_nx   = gate_len;
                    arm_nx   = 1'b0;
                    count_nx = '0;
                    ovf_nx   = 1'b0;
                    state_nx = ARM;
                end
            end
            ARM: begin
                // Two cycles let the synchroniser and history flop settle before counting.
                arm_nx = 1'b1;
                if (arm_cnt) begin
                    state_nx = (win_cnt == '0) ? DONE : GATE;
                end
            end
            GATE: begin
                win_nx = win_cnt - 1'b1;
                if (rise) begin
                    if (count_q == {CNT_W{1'b1}}) begin
                        ovf_nx = 1'b1;
                    end else begin
                        count_nx = count_q + 1'b1;
                    end
                end
                if (win_cnt == GATE_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            hist    <= 1'b0;
            arm_cnt <= 1'b0;
            win_cnt <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            sync_a  <= osc_in;
            sync_b  <= sync_a;
            hist    <= sync_b;
            arm_cnt <= arm_nx;
            win_cnt <= win_nx;
            count_q <= count_nx;
            ovf_q   <= ovf_nx;
            busy_q  <= (state_nx == ARM) || (state_nx == GATE);
            valid_q <= (state_nx == DONE);
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign count        = count_q;
    assign overflow     = ovf_q;

`ifdef ROSC_MINMAX_EN
    logic [CNT_W-1:0] min_q, max_q;

    // Updated with the final window count on the edge that enters DONE; a clear wins over that update.
    always_ff @(posedge clk) begin
        if (!rst_n || minmax_clr) begin
            min_q <= {CNT_W{1'b1}};
            max_q <= '0;
        end else if (state_nx == DONE && state != DONE) begin
            if (count_nx < min_q) min_q <= count_nx;
            if (count_nx > max_q) max_q <= count_nx;
        end
    end

    assign min_count = min_q;
    assign max_count = max_q;
`endif

endmodule

// File: tb/tb_rosc_freq_meter.sv
// Bench for rosc_freq_meter: a 16-bit and a 4-bit counter instance share all stimulus and are checked
// against edge counts derived from the sampled oscillator waveform.
module tb_rosc_freq_meter;

    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          osc = 1'b0;
    logic          start = 1'b0;
    logic [GW-1:0] gate_len = '0;
    logic          result_ready = 1'b0;
    logic          busy, rv, ovf;
    logic [15:0]   count;
    logic          busy4, rv4, ovf4;
    logic [3:0]    count4;
`ifdef ROSC_MINMAX_EN
    logic          minmax_clr = 1'b0;
    logic [15:0]   min_c, max_c;
    logic [3:0]    min4, max4;
    int            mm_min = 65535, mm_max = 0, mm_min4 = 15, mm_max4 = 0;
`endif

    int total = 0;
    int bad = 0;
    int osc_half = 2;
    int samp[$];

    rosc_freq_meter #(.GATE_W(GW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc), .start(start), .gate_len(gate_len),
        .busy(busy), .result_valid(rv), .result_ready(result_ready),
        .count(count), .overflow(ovf)
`ifdef ROSC_MINMAX_EN
        , .minmax_clr(minmax_clr), .min_count(min_c), .max_count(max_c)
`endif
    );

    rosc_freq_meter #(.GATE_W(GW), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .osc_in(osc), .start(start), .gate_len(gate_len),
        .busy(busy4), .result_valid(rv4), .result_ready(result_ready),
        .count(count4), .overflow(ovf4)
`ifdef ROSC_MINMAX_EN
        , .minmax_clr(minmax_clr), .min_count(min4), .max_count(max4)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // oscillator: toggles 3 time units after a clk edge, every osc_half clocks (0 = random half period)
    initial begin
        int h;
        forever begin
            h = (osc_half == 0) ? int'($urandom_range(1, 6)) : osc_half;
            repeat (h) @(posedge clk);
            #3 osc = ~osc;
        end
    end

    // osc value seen at every clk edge, indexed by edge number
    always @(posedge clk) samp.push_back(int'(osc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rising edges between consecutive samples from the start-accept edge to L edges later.
    function automatic int model_rises(input int e0, input int len);
        int n = 0;
        for (int i = 0; i < len; i++) begin
            if (samp[e0 + i] == 0 && samp[e0 + i + 1] == 1) n++;
        end
        return n;
    endfunction

    task automatic run_meas(input int len, input int hold, input bit poke, input logic [GW-1:0] late_len);
        int          e0, lat, rises, exp16, exp4;
        bit          busy_ok, hold_ok;
        logic [15:0] c_snap;
        @(negedge clk);
        start = 1'b1;
        gate_len = len[GW-1:0];
        @(posedge clk);
        #1 e0 = samp.size() - 1;
        @(negedge clk);
        start = 1'b0;
        gate_len = late_len;
        lat = 1;
        busy_ok = 1'b1;
        while (rv !== 1'b1 && lat < len + 20) begin
            if (busy !== 1'b1 || busy4 !== 1'b1) busy_ok = 1'b0;
            start = poke && (lat == 4);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, len + 3);
        chk("busy_window", busy_ok, 1);
        chk("busy_in_done", busy, 0);
        rises = model_rises(e0, len);
        exp16 = (rises > 65535) ? 65535 : rises;
        exp4  = (rises > 15) ? 15 : rises;
        chk("count16", count, exp16);
        chk("ovf16", ovf, rises > 65535);
        chk("valid4", rv4, 1);
        chk("count4", count4, exp4);
        chk("ovf4", ovf4, rises > 15);
`ifdef ROSC_MINMAX_EN
        if (exp16 < mm_min) mm_min = exp16;
        if (exp16 > mm_max) mm_max = exp16;
        if (exp4 < mm_min4) mm_min4 = exp4;
        if (exp4 > mm_max4) mm_max4 = exp4;
        chk("min16", min_c, mm_min);
        chk("max16", max_c, mm_max);
        chk("min4", min4, mm_min4);
        chk("max4", max4, mm_max4);
`endif
        hold_ok = 1'b1;
        c_snap = count;
        repeat (hold) begin
            @(negedge clk);
            if (rv !== 1'b1 || count !== c_snap || busy !== 1'b0 || count4 !== exp4[3:0]) hold_ok = 1'b0;
        end
        chk("hold_stable", hold_ok, 1);
        result_ready = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        result_ready = 1'b0;
        start = 1'b0;
        chk("exit_valid", rv, 0);
        chk("exit_busy", busy, 0);
        @(negedge clk);
        chk("no_restart", busy, 0);
        chk("idle_count_held", count, exp16);
    endtask

    initial begin
        int e;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rv, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
`ifdef ROSC_MINMAX_EN
        chk("rst_min", min_c, 16'hffff);
        chk("rst_max", max_c, 0);
`endif
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // period 4, L=100, start poked mid-window and gate_len changed to 5; 4-bit instance saturates
        run_meas(100, 50, 1'b1, 16'd5);
        chk("period4_count", count, 25);
        chk("period4_ovf", ovf, 0);
        chk("sat_count4", count4, 15);
        chk("sat_ovf4", ovf4, 1);

        run_meas(40, 2, 1'b0, 16'($urandom));
        chk("period4_l40", count, 10);
`ifdef ROSC_MINMAX_EN
        chk("mm_min_10", min_c, 10);
        chk("mm_max_25", max_c, 25);
        @(negedge clk);
        minmax_clr = 1'b1;
        @(negedge clk);
        minmax_clr = 1'b0;
        mm_min = 65535; mm_max = 0; mm_min4 = 15; mm_max4 = 0;
        chk("clr_min", min_c, 16'hffff);
        chk("clr_max", max_c, 0);
`endif

        // zero-length window
        run_meas(0, 1, 1'b0, 16'($urandom));
        chk("zero_count", count, 0);
        chk("zero_ovf", ovf, 0);

        // reset in the middle of a window
        @(negedge clk);
        start = 1'b1;
        gate_len = 16'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rv, 0);
        chk("midrst_count", count, 0);
        chk("midrst_ovf4", ovf4, 0);
`ifdef ROSC_MINMAX_EN
        mm_min = 65535; mm_max = 0; mm_min4 = 15; mm_max4 = 0;
`endif
        repeat (5) @(negedge clk);
        chk("midrst_idle", busy, 0);
        run_meas(100, 0, 1'b0, 16'($urandom));
        chk("after_rst_count", count, 25);

        // randomized windows and oscillator rates
        for (int i = 0; i < 12; i++) begin
            osc_half = (i % 3 == 0) ? 0 : int'($urandom_range(1, 5));
            e = $urandom_range(3, 12);
            repeat (e) @(negedge clk);
            run_meas($urandom_range(0, 150), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
